// File: rtl/serial_packet_ctrl.sv
// Framed write-packet parser behind the serial receiver: ADDR, LEN, payload, CSUM.
// Payload is buffered and replayed as register writes only after the checksum validates.
module serial_packet_ctrl #(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned LEN_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_strobe,
  input  logic                 rx_idle,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic                 wr_strobe,
  output logic                 pkt_ok,
  output logic                 pkt_err,
  output logic [7:0]           err_count
);

  localparam int unsigned IDX_BITS  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_COMMIT,
    S_RESYNC
  } state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   base;
  logic [LEN_BITS-1:0]    len;
  logic [LEN_BITS-1:0]    idx;
  logic [7:0]             sum;
  logic                   overrun;
  logic [7:0]             buffer [MAX_LEN];

  logic [7:0]             sum_next;
  logic [IDX_BITS-1:0]    buf_idx;
  logic                   raise_err;

  assign sum_next = sum + rx_data;
  assign buf_idx  = idx[IDX_BITS-1:0];

  // Every reject condition in one place; an idle abort takes priority over a same-cycle byte.
  always_comb begin
    raise_err = 1'b0;
    case (state)
      S_LEN:     raise_err = rx_idle ||
                             (rx_strobe && ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)));
      S_PAYLOAD: raise_err = rx_idle;
      S_CSUM:    raise_err = rx_idle || (rx_strobe && (sum_next != 8'd0));
      S_COMMIT:  raise_err = rx_strobe;
      default:   raise_err = 1'b0;
    endcase
  end

  // Payload storage; contents are meaningless until a checksum passes, so no reset.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && rx_strobe && !rx_idle) begin
      buffer[buf_idx] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      base      <= '0;
      len       <= '0;
      idx       <= '0;
      sum       <= 8'd0;
      overrun   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
      wr_strobe <= 1'b0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      pkt_ok    <= 1'b0;
      pkt_err   <= raise_err;
      if (raise_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (rx_strobe) begin
            base    <= ADDR_BITS'(rx_data);
            sum     <= rx_data;
            idx     <= '0;
            overrun <= 1'b0;
            state   <= S_LEN;
          end
        end

        S_LEN: begin
          if (rx_idle) begin
            state <= S_IDLE;
          end else if (rx_strobe) begin
            if (raise_err) begin
              state <= S_RESYNC;
            end else begin
              len   <= LEN_BITS'(rx_data);
              sum   <= sum_next;
              idx   <= '0;
              state <= S_PAYLOAD;
            end
          end
        end

        S_PAYLOAD: begin
          if (rx_idle) begin
            state <= S_IDLE;
          end else if (rx_strobe) begin
            sum <= sum_next;
            if (idx == len - LEN_BITS'(1)) begin
              idx   <= '0;
              state <= S_CSUM;
            end else begin
              idx <= idx + LEN_BITS'(1);
            end
          end
        end

        // A good checksum issues the first write immediately so the burst starts at T+1.
        S_CSUM: begin
          if (rx_idle) begin
            state <= S_IDLE;
          end else if (rx_strobe) begin
            if (raise_err) begin
              state <= S_RESYNC;
            end else begin
              wr_strobe <= 1'b1;
              wr_addr   <= base;
              wr_data   <= buffer[buf_idx];
              idx       <= LEN_BITS'(1);
              state     <= S_COMMIT;
            end
          end
        end

        // Bytes arriving here are dropped but flagged; the burst itself always completes.
        S_COMMIT: begin
          if (rx_strobe) begin
            overrun <= 1'b1;
          end
          if (idx == len) begin
            pkt_ok <= 1'b1;
            state  <= (overrun || rx_strobe) ? S_RESYNC : S_IDLE;
          end else begin
            wr_strobe <= 1'b1;
            wr_addr   <= base + ADDR_BITS'(idx);
            wr_data   <= buffer[buf_idx];
            idx       <= idx + LEN_BITS'(1);
          end
        end

        S_RESYNC: begin
          if (rx_idle) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_packet_ctrl.md
# serial_packet_ctrl

Packet-level controller that sits directly behind the 8-N-1 serial receiver. It consumes the received byte stream and framing-idle indication, and parses framed write packets: address, length, payload, checksum. Payload is buffered until the checksum validates, then committed as a burst of single-cycle register writes to the downstream register file. Malformed, corrupted or overrun packets are rejected atomically: either a whole packet is written or nothing is.

## Interface
Parameters:
- ADDR_BITS, 4, width of write address; address byte bits above ADDR_BITS are ignored
- MAX_LEN, 16, largest legal payload length in bytes (1..255)
- LEN_BITS, 5, counter width; must hold MAX_LEN

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- rx_data  in  8  received byte, valid when rx_strobe=1
- rx_strobe  in  1  one-cycle pulse per good byte
- rx_idle  in  1  level; line idle past timeout (receiver's idle_timeout)
- wr_addr  out  ADDR_BITS  register write address
- wr_data  out  8  register write data
- wr_strobe  out  1  one-cycle write enable per byte
- pkt_ok  out  1  one-cycle pulse, packet committed
- pkt_err  out  1  one-cycle pulse, packet rejected
- err_count  out  8  rejected-packet count, saturates at 0xFF

## Operation
- Packet: ADDR, LEN, LEN payload bytes, CSUM. Valid iff the 8-bit sum of all bytes including CSUM is 0x00 (mod 256).
- States:
  - IDLE: next strobe latches base address and starts the running sum -> LEN.
  - LEN: strobe with value 0 or >MAX_LEN -> error -> RESYNC; otherwise latch length -> PAYLOAD.
  - PAYLOAD: each strobe stores the byte in buffer[index] and advances index; after the LEN-th byte -> CSUM.
  - CSUM: strobe adds CSUM to the running sum; zero -> COMMIT; nonzero -> error -> RESYNC.
  - COMMIT: one write per cycle for index 0..LEN-1; wr_addr = (base + index) mod 2^ADDR_BITS (wraps); then pkt_ok -> IDLE.
  - RESYNC: ignore strobes until rx_idle=1 -> IDLE.
- Idle mid-packet: rx_idle=1 in LEN/PAYLOAD/CSUM -> error -> IDLE.
- Overrun: rx_strobe during COMMIT drops the byte, and the commit still completes with pkt_ok. The same cycle raises pkt_err and counts an error; next state after commit is RESYNC, not IDLE.
- Error action: pkt_err pulse, err_count+1 (saturating), no writes issued.
- Reset mid-operation: return to IDLE immediately, with no partial writes. Buffer contents are don't-care.

## Timing
- Reset values: wr_addr=0, wr_data=0, wr_strobe=0, pkt_ok=0, pkt_err=0, err_count=0, state IDLE.
- CSUM strobe at cycle T (good): wr_strobe high T+1..T+LEN with data buffer[0..LEN-1]. pkt_ok high at T+LEN+1; IDLE at T+LEN+1.
- CSUM bad or LEN illegal at T: pkt_err at T+1, err_count updated at T+1, wr_strobe never asserts.
- Idle abort: rx_idle sampled 1 at T in a mid-packet state -> pkt_err at T+1.
- rx_idle is ignored in IDLE and COMMIT; in RESYNC it is the only exit.
- rx_strobe and rx_idle in the same cycle in LEN/PAYLOAD/CSUM: the idle abort wins and the byte is discarded.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Good packet 0x10,0x02,0xAA,0x55,0xEF (ADDR_BITS=4) -> writes addr 0x0 data 0xAA, addr 0x1 data 0x55 on consecutive cycles, then pkt_ok; err_count=0.
- Wrap: 0x0E,0x03,0x01,0x02,0x03,0xE9 -> writes 0xE/0x01, 0xF/0x02, 0x0/0x03; pkt_ok.
- Bad checksum: 0x10,0x02,0xAA,0x55,0xEE -> pkt_err, no wr_strobe, err_count=1. A following good packet sent without idle is ignored; the same packet after rx_idle pulse commits.
- Illegal length: 0x05,0x00 and 0x05,0x11 (MAX_LEN=16) -> pkt_err after the LEN byte, err_count increments, RESYNC entered.
- Idle abort: 0x10,0x02,0xAA then rx_idle=1 -> pkt_err, IDLE; next good packet commits normally.
- Overrun/reset: strobe during COMMIT of a 16-byte packet -> all 16 writes plus pkt_ok and pkt_err, then RESYNC. Separately, assert reset during PAYLOAD -> all outputs at reset values, no writes. Drive 300 bad packets -> err_count holds 0xFF.
